// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned, abortable.
// Optional macro DIV_ZERO_FLAG_EN adds the dz output flagging a zero divisor in the done cycle.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
`ifdef DIV_ZERO_FLAG_EN
  output logic [WIDTH-1:0] remainder,
  output logic             dz
`else
  output logic [WIDTH-1:0] remainder
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic             neg_q, neg_r, dvs_zero;
  logic             accept;

  // Datapath next values for one iteration; dvd collects quotient bits in its lsb.
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_step, dvd_step;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;

  assign accept   = start && (state == IDLE || state == DONE);
  assign a_abs    = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs    = (is_signed && b[WIDTH-1]) ? -b : b;
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign ge       = shifted >= {1'b0, dvs};
  assign rem_step = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
  assign dvd_step = {dvd[WIDTH-2:0], ge};
  // A zero divisor already yields an all-ones magnitude; forcing it skips sign correction.
  assign q_fix    = dvs_zero ? '1 : (neg_q ? -dvd : dvd);
  assign r_fix    = neg_r ? -rem : rem;

  assign busy = (state == BUSY) || (state == FIX);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = BUSY;
      BUSY: begin
        if (abort)         state_nxt = IDLE;
        else if (cnt == 1) state_nxt = FIX;
      end
      FIX:  state_nxt = abort ? IDLE : DONE;
      DONE: state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvs_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= CNT_INIT;
        rem      <= '0;
        dvd      <= a_abs;
        dvs      <= b_abs;
        neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r    <= is_signed && a[WIDTH-1];
        dvs_zero <= (b == '0);
      end else if (state == BUSY && !abort) begin
        cnt <= cnt - 1'b1;
        rem <= rem_step;
        dvd <= dvd_step;
      end
      if (state == FIX && !abort) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) dz <= 1'b0;
    else     dz <= (state == FIX) && !abort && dvs_zero;
  end
`endif

endmodule
